// File: rtl/int_ctrl.sv
// Three-source interrupt controller: ext/timer/sw triggers, mask, gie,
// and an IDLE -> REQ -> SERVICE request/acknowledge handshake.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   ext_int        asynchronous external pin, rising edge triggers
//   timer_int      synchronous level, rising edge triggers
//   sw_int         synchronous strobe, every high cycle triggers
//   mask_we/in     mask register write (bit=1 masks source)
//   gie_set/clr    global interrupt enable control (clr wins)
//   int_ack, reti  handshake strobes from the controller
//   int_req/vec    registered request and vector (VEC_BASE + id)
//   pending, mask, gie, in_service   status
module int_ctrl #(
   parameter logic [7:0] VEC_BASE    = 8'hF0,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ext_int,
   input  logic       timer_int,
   input  logic       sw_int,
   input  logic       mask_we,
   input  logic [2:0] mask_in,
   input  logic       gie_set,
   input  logic       gie_clr,
   input  logic       int_ack,
   input  logic       reti,
   output logic       int_req,
   output logic [7:0] int_vec,
   output logic [2:0] pending,
   output logic [2:0] mask,
   output logic       gie,
   output logic       in_service
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] SERVICE = 2'd2;

   logic [1:0]             state;
   logic [1:0]             cur_id;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ext_prev;
   logic                   timer_prev;

   logic       ext_rise;
   logic       timer_rise;
   logic [2:0] set_vec;
   logic [2:0] clr_vec;
   logic [2:0] elig;
   logic [1:0] nxt_id;
   logic       take;
   logic       ack_go;
   logic       reti_go;

   assign ext_rise   = sync_q[SYNC_STAGES-1] & ~ext_prev;
   assign timer_rise = timer_int & ~timer_prev;
   assign set_vec    = {sw_int, timer_rise, ext_rise};

   assign elig    = pending & ~mask;
   assign take    = (state == IDLE) && gie && (elig != 3'b000);
   assign ack_go  = (state == REQ) && int_ack;
   assign reti_go = (state == SERVICE) && reti;

   // Fixed priority: ext > timer > sw
   always_comb begin
      nxt_id = 2'd2;
      if (elig[0])
         nxt_id = 2'd0;
      else if (elig[1])
         nxt_id = 2'd1;
   end

   assign clr_vec = {cur_id == 2'd2, cur_id == 2'd1, cur_id == 2'd0}
                  & {3{ack_go}};

   assign in_service = (state == SERVICE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= '0;
         ext_prev   <= 1'b0;
         timer_prev <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], ext_int};
         ext_prev   <= sync_q[SYNC_STAGES-1];
         timer_prev <= timer_int;
      end
   end

   // A trigger landing on the ack edge re-sets the bit being cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pending <= 3'b000;
      else
         pending <= (pending & ~clr_vec) | set_vec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mask <= 3'b111;
      else if (mask_we)
         mask <= mask_in;
   end

   // FSM-driven gie updates take precedence over software set/clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         gie <= 1'b0;
      else if (ack_go)
         gie <= 1'b0;
      else if (reti_go)
         gie <= 1'b1;
      else if (gie_clr)
         gie <= 1'b0;
      else if (gie_set)
         gie <= 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cur_id  <= 2'd0;
         int_req <= 1'b0;
         int_vec <= VEC_BASE;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  state   <= REQ;
                  cur_id  <= nxt_id;
                  int_req <= 1'b1;
                  int_vec <= VEC_BASE + {6'b0, nxt_id};
               end
            end
            REQ: begin
               if (int_ack) begin
                  state   <= SERVICE;
                  int_req <= 1'b0;
               end
            end
            SERVICE: begin
               if (reti)
                  state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               int_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed testbench for int_ctrl.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_int_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       ext_int;
   logic       timer_int;
   logic       sw_int;
   logic       mask_we;
   logic [2:0] mask_in;
   logic       gie_set;
   logic       gie_clr;
   logic       int_ack;
   logic       reti;
   logic       int_req;
   logic [7:0] int_vec;
   logic [2:0] pending;
   logic [2:0] mask;
   logic       gie;
   logic       in_service;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   int_ctrl #(.VEC_BASE(8'hF0), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .ext_int    (ext_int),
      .timer_int  (timer_int),
      .sw_int     (sw_int),
      .mask_we    (mask_we),
      .mask_in    (mask_in),
      .gie_set    (gie_set),
      .gie_clr    (gie_clr),
      .int_ack    (int_ack),
      .reti       (reti),
      .int_req    (int_req),
      .int_vec    (int_vec),
      .pending    (pending),
      .mask       (mask),
      .gie        (gie),
      .in_service (in_service)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      ext_int = 0; timer_int = 0; sw_int = 0;
      mask_we = 0; mask_in = 3'b000;
      gie_set = 0; gie_clr = 0; int_ack = 0; reti = 0;
      tick();
      tick();
      chk("rst_req", int_req, 0);
      chk("rst_vec", int_vec, 8'hF0);
      chk("rst_pend", pending, 3'b000);
      chk("rst_mask", mask, 3'b111);
      chk("rst_gie", gie, 0);
      chk("rst_svc", in_service, 0);
      rst = 1'b0;
      tick();

      // sw source: mask=0, gie=1
      mask_we = 1; mask_in = 3'b000; gie_set = 1;
      tick();
      mask_we = 0; gie_set = 0;
      chk("s1_mask", mask, 3'b000);
      chk("s1_gie", gie, 1);
      sw_int = 1;
      tick();
      sw_int = 0;
      chk("s1_pend", pending, 3'b100);
      chk("s1_req_early", int_req, 0);
      tick();
      chk("s1_req", int_req, 1);
      chk("s1_vec", int_vec, 8'hF2);
      tick();
      chk("s1_req_hold", int_req, 1);
      int_ack = 1;
      tick();
      int_ack = 0;
      chk("s1_ack_pend", pending, 3'b000);
      chk("s1_ack_gie", gie, 0);
      chk("s1_ack_svc", in_service, 1);
      chk("s1_ack_req", int_req, 0);
      chk("s1_vec_hold", int_vec, 8'hF2);
      reti = 1;
      tick();
      reti = 0;
      chk("s1_reti_gie", gie, 1);
      chk("s1_reti_svc", in_service, 0);

      // timer and sw together: timer first
      timer_int = 1; sw_int = 1;
      tick();
      sw_int = 0;
      chk("s2_pend", pending, 3'b110);
      tick();
      chk("s2_req1", int_req, 1);
      chk("s2_vec1", int_vec, 8'hF1);
      int_ack = 1;
      tick();
      int_ack = 0;
      chk("s2_pend_a", pending, 3'b100);
      reti = 1;
      tick();
      reti = 0;
      chk("s2_req_idle", int_req, 0);
      tick();
      chk("s2_req2", int_req, 1);
      chk("s2_vec2", int_vec, 8'hF2);
      int_ack = 1;
      tick();
      int_ack = 0;
      reti = 1;
      tick();
      reti = 0;
      chk("s2_level_once", pending, 3'b000);
      timer_int = 0;
      tick();

      // masked timer, then unmask
      mask_we = 1; mask_in = 3'b010;
      tick();
      mask_we = 0;
      timer_int = 1;
      tick();
      chk("s3_pend", pending, 3'b010);
      tick();
      chk("s3_masked", int_req, 0);
      mask_we = 1; mask_in = 3'b000;
      tick();
      mask_we = 0;
      chk("s3_mask0", mask, 3'b000);
      tick();
      chk("s3_req", int_req, 1);
      chk("s3_vec", int_vec, 8'hF1);
      int_ack = 1;
      tick();
      int_ack = 0;
      timer_int = 0;

      // ext during SERVICE: sync latency 2 + edge detect
      ext_int = 1;
      tick();
      tick();
      chk("s4_pend_early", pending[0], 0);
      tick();
      chk("s4_pend", pending, 3'b001);
      chk("s4_noreq", int_req, 0);
      chk("s4_svc", in_service, 1);
      reti = 1;
      tick();
      reti = 0;
      chk("s4_gie", gie, 1);
      chk("s4_req_idle", int_req, 0);
      tick();
      chk("s4_req", int_req, 1);
      chk("s4_vec", int_vec, 8'hF0);
      int_ack = 1;
      tick();
      int_ack = 0;
      reti = 1;
      tick();
      reti = 0;
      ext_int = 0;

      // gie set/clr together, ack in IDLE
      gie_set = 1; gie_clr = 1;
      tick();
      gie_set = 0; gie_clr = 0;
      chk("s5_gie", gie, 0);
      int_ack = 1;
      tick();
      int_ack = 0;
      chk("s5_svc", in_service, 0);
      chk("s5_req", int_req, 0);
      chk("s5_pend", pending, 3'b000);

      // set wins on the ack edge
      gie_set = 1;
      tick();
      gie_set = 0;
      sw_int = 1;
      tick();
      sw_int = 0;
      tick();
      chk("s6_req", int_req, 1);
      chk("s6_vec", int_vec, 8'hF2);
      int_ack = 1; sw_int = 1;
      tick();
      int_ack = 0; sw_int = 0;
      chk("s6_setwins", pending, 3'b100);
      chk("s6_svc", in_service, 1);
      reti = 1;
      tick();
      reti = 0;
      tick();
      chk("s6_req2", int_req, 1);

      // async reset mid-REQ
      rst = 1;
      #1;
      chk("s7_req", int_req, 0);
      chk("s7_mask", mask, 3'b111);
      chk("s7_pend", pending, 3'b000);
      chk("s7_gie", gie, 0);
      chk("s7_vec", int_vec, 8'hF0);
      tick();
      rst = 0;
      mask_we = 1; mask_in = 3'b000; gie_set = 1;
      tick();
      mask_we = 0; gie_set = 0;
      tick();
      chk("s7_nofresh", int_req, 0);
      chk("s7_svc", in_service, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL have parameter VEC_BASE, default 8'hF0, the interrupt vector of source 0.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on ext_int (minimum 2).
REQ-003 The block SHALL have a single clock and an asynchronous, active-high reset, and its ports SHALL be:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- ext_int  in  1  external interrupt pin; asynchronous; rising edge triggers
- timer_int  in  1  timer interrupt level; synchronous to clk; rising edge triggers
- sw_int  in  1  software interrupt strobe; synchronous; each high cycle triggers
- mask_we  in  1  write strobe for the mask register
- mask_in  in  3  mask write data; bit i=1 masks source i
- gie_set  in  1  set the global interrupt enable
- gie_clr  in  1  clear the global interrupt enable
- int_ack  in  1  acknowledge from the controller
- reti  in  1  return-from-interrupt strobe from the controller
- int_req  out  1  interrupt request to the controller
- int_vec  out  8  vector of the requested source
- pending  out  3  pending flags (bit0 ext, bit1 timer, bit2 sw)
- mask  out  3  current mask register
- gie  out  1  global interrupt enable
- in_service  out  1  an interrupt is being serviced

Function
REQ-004 The block SHALL pass ext_int through SYNC_STAGES flops, and SHALL set pending[0] on the edge after the synchronized value goes 0->1.
REQ-005 The block SHALL set pending[1] on the clock edge that samples timer_int=1 when the previous sample was 0; a level held high SHALL set it only once.
REQ-006 The block SHALL set pending[2] on every edge that samples sw_int=1.
REQ-007 Pending bits SHALL be set independently of mask and gie, and SHALL hold until cleared by acknowledge.
REQ-008 The block SHALL implement a three-state FSM: IDLE, REQ, SERVICE.
REQ-009 IDLE: when gie=1 and (pending & ~mask)!=0, the FSM SHALL move to REQ on the next edge, latching cur_id as the lowest-index eligible source (priority ext > timer > sw).
REQ-010 In REQ, int_req SHALL be 1 and int_vec SHALL be VEC_BASE+cur_id (8-bit, wrap modulo 256); both outputs SHALL be registered.
REQ-011 Once in REQ, the request SHALL NOT be withdrawn or re-prioritized by mask, gie or new pending changes until int_ack.
REQ-012 REQ with int_ack=1: on the next edge the block SHALL clear pending[cur_id], clear gie, drop int_req to 0 and enter SERVICE.
REQ-013 If a new trigger for cur_id arrives on the ack edge, the set SHALL win and the bit SHALL stay pending.
REQ-014 SERVICE: in_service SHALL be 1; triggers SHALL continue to latch; there is no nesting.
REQ-015 SERVICE with reti=1: on the next edge the block SHALL set gie=1 and return to IDLE.
REQ-016 int_ack outside REQ and reti outside SERVICE SHALL be ignored.
REQ-017 gie_set and gie_clr asserted together: clr SHALL win; the FSM's own gie updates (REQ-012, REQ-015) SHALL override both.
REQ-018 mask_we SHALL load mask_in on the next edge in any state.
REQ-019 int_vec SHALL hold its last value outside REQ.
REQ-020 Latency (int_req rising at edge, with gie=1, unmasked, in IDLE):
- timer or sw trigger sampled at edge N -> pending at N, int_req at N+1
- ext_int stable high before edge N -> int_req at edge N+SYNC_STAGES+1

Reset
REQ-021 While rst=1, the block SHALL force, asynchronously: FSM=IDLE, pending=0, mask=3'b111, gie=0, int_req=0, int_vec=VEC_BASE, in_service=0, and clear the synchronizer and edge-detect flops.
REQ-022 Reset asserted mid-REQ or mid-SERVICE SHALL discard the request without any ack side effects; the first request after release SHALL require a fresh trigger.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- mask=0, gie=1, pulse sw_int at edge 10 -> int_req=1 at edge 11, int_vec=8'hF2; ack -> pending[2]=0, gie=0, in_service=1.
- timer_int and sw_int both rise at the same edge -> int_vec=8'hF1 first; after reti, second request int_vec=8'hF2.
- mask=3'b010, timer_int rises -> pending[1]=1, int_req stays 0; then write mask=0 -> int_req on the following edge.
- ext_int rises during SERVICE -> pending[0]=1, no int_req; reti -> gie=1, int_req one edge after IDLE, int_vec=8'hF0.
- gie_set and gie_clr in the same cycle -> gie=0; int_ack while in IDLE -> no state change.
- rst asserted while int_req=1 -> int_req=0, mask=3'b111 immediately, before any clock edge.
